// File: rtl/s_top_uart_tx.sv
// 64-bit word UART transmitter: eight 8N1 (or 8-parity-1) frames, MSB byte first, LSB bit first.
// A sticky completion flag blocks re-sending the same word until the host acknowledges it.
module s_top_uart_tx #(
    parameter int unsigned CLKS_PER_BIT = 434
) (
    input  logic        clk,
    input  logic        rst_m,
    input  logic        parity_en,
    input  logic        parity_kind,
    input  logic        read,
    input  logic [63:0] data,
    input  logic        txd_en,
    output logic        txd,
    output logic        ft
);

    localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP,
        S_GAP
    } state_e;

    state_e           state_q;
    logic [CNT_W-1:0] baud_q;
    logic [2:0]       bit_idx_q;
    logic [2:0]       byte_idx_q;
    logic [63:0]      word_q;
    logic [7:0]       shift_q;
    logic             par_en_q;
    logic             par_bit_q;
    logic             txd_q;
    logic             ft_q;

    logic             baud_done_c;
    logic             launch_c;
    logic [7:0]       next_byte_c;

    assign baud_done_c = (baud_q == BAUD_LAST);

    // Byte to load when a frame launches; in STOP the word has not yet been shifted.
    always_comb begin
        next_byte_c = word_q[63:56];
        if (state_q == S_IDLE) begin
            next_byte_c = data[63:56];
        end else if (state_q == S_STOP) begin
            next_byte_c = word_q[55:48];
        end
    end

    always_comb begin
        launch_c = 1'b0;
        case (state_q)
            S_IDLE:  launch_c = txd_en && !ft_q;
            S_GAP:   launch_c = txd_en;
            S_STOP:  launch_c = baud_done_c && (byte_idx_q != 3'd7) && txd_en;
            default: launch_c = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_m) begin
        if (!rst_m) begin
            state_q    <= S_IDLE;
            baud_q     <= '0;
            bit_idx_q  <= '0;
            byte_idx_q <= '0;
            word_q     <= '0;
            shift_q    <= '0;
            par_en_q   <= 1'b0;
            par_bit_q  <= 1'b0;
            txd_q      <= 1'b1;
            ft_q       <= 1'b0;
        end else begin
            // Host acknowledge; a completion in the same cycle overrides this below.
            if (read) begin
                ft_q <= 1'b0;
            end

            case (state_q)
                S_IDLE: begin
                    txd_q  <= 1'b1;
                    baud_q <= '0;
                    if (launch_c) begin
                        word_q     <= data;
                        byte_idx_q <= '0;
                    end
                end

                S_START: begin
                    if (baud_done_c) begin
                        baud_q    <= '0;
                        bit_idx_q <= '0;
                        txd_q     <= shift_q[0];
                        state_q   <= S_DATA;
                    end else begin
                        baud_q <= baud_q + 1'b1;
                    end
                end

                S_DATA: begin
                    if (baud_done_c) begin
                        baud_q <= '0;
                        if (bit_idx_q == 3'd7) begin
                            if (par_en_q) begin
                                txd_q   <= par_bit_q;
                                state_q <= S_PARITY;
                            end else begin
                                txd_q   <= 1'b1;
                                state_q <= S_STOP;
                            end
                        end else begin
                            shift_q   <= {1'b0, shift_q[7:1]};
                            txd_q     <= shift_q[1];
                            bit_idx_q <= bit_idx_q + 3'd1;
                        end
                    end else begin
                        baud_q <= baud_q + 1'b1;
                    end
                end

                S_PARITY: begin
                    if (baud_done_c) begin
                        baud_q  <= '0;
                        txd_q   <= 1'b1;
                        state_q <= S_STOP;
                    end else begin
                        baud_q <= baud_q + 1'b1;
                    end
                end

                S_STOP: begin
                    if (baud_done_c) begin
                        baud_q <= '0;
                        if (byte_idx_q == 3'd7) begin
                            ft_q    <= 1'b1;
                            state_q <= S_IDLE;
                        end else begin
                            byte_idx_q <= byte_idx_q + 3'd1;
                            word_q     <= {word_q[55:0], 8'h00};
                            state_q    <= S_GAP;
                        end
                    end else begin
                        baud_q <= baud_q + 1'b1;
                    end
                end

                S_GAP: begin
                    txd_q  <= 1'b1;
                    baud_q <= '0;
                end

                default: begin
                    txd_q   <= 1'b1;
                    state_q <= S_IDLE;
                end
            endcase

            // Frame launch: start bit plus per-frame parity settings, sampled here.
            if (launch_c) begin
                state_q   <= S_START;
                txd_q     <= 1'b0;
                baud_q    <= '0;
                bit_idx_q <= '0;
                shift_q   <= next_byte_c;
                par_en_q  <= parity_en;
                par_bit_q <= (^next_byte_c) ^ parity_kind;
            end
        end
    end

    assign txd = txd_q;
    assign ft  = ft_q;

endmodule

// File: tb/tb_s_top_uart_tx.sv
// Bench for s_top_uart_tx: a serial-line monitor decodes frames and checks them against a
// scoreboard of hand-computed bytes/parity pushed by the directed stimulus.
module tb_s_top_uart_tx;

    localparam int unsigned CPB   = 4;
    localparam int unsigned LIMIT = 3000;

    logic        clk;
    logic        rst_m;
    logic        parity_en;
    logic        parity_kind;
    logic        read;
    logic [63:0] data;
    logic        txd_en;
    logic        txd;
    logic        ft;

    s_top_uart_tx #(.CLKS_PER_BIT(CPB)) dut (
        .clk         (clk),
        .rst_m       (rst_m),
        .parity_en   (parity_en),
        .parity_kind (parity_kind),
        .read        (read),
        .data        (data),
        .txd_en      (txd_en),
        .txd         (txd),
        .ft          (ft)
    );

    typedef struct packed {
        logic [7:0] b;
        logic       pe;
        logic       pb;
    } exp_t;

    // Bytes of 64'hC16B85393ADB0ECB in send order, and their even-parity bits.
    localparam logic [7:0] BYTES [8] = '{8'hC1, 8'h6B, 8'h85, 8'h39, 8'h3A, 8'hDB, 8'h0E, 8'hCB};
    localparam logic       PEVEN [8] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    logic quiet  = 1'b0;

    initial clk = 1'b0;
    always #10 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic push_word(input logic pe, input logic kind);
        for (int i = 0; i < 8; i++) begin
            sb_q.push_back('{b: BYTES[i], pe: pe, pb: PEVEN[i] ^ kind});
        end
    endtask

    task automatic wait_fall(output int c);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (txd !== 1'b0 && n < LIMIT);
        c = cyc;
        checks++;
        if (n >= LIMIT) begin
            errors++;
            $display("FAIL txd_fall_timeout: got no start bit within %0d clks", LIMIT);
        end
    endtask

    task automatic wait_ft(output int c);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (ft !== 1'b1 && n < LIMIT);
        c = cyc;
        checks++;
        if (n >= LIMIT) begin
            errors++;
            $display("FAIL ft_timeout: got ft=%b, required 1 within %0d clks", ft, LIMIT);
        end
    endtask

    task automatic ack_ft();
        @(negedge clk);
        txd_en = 1'b0;
        read   = 1'b1;
        @(negedge clk);
        read = 1'b0;
        check("ft_cleared_by_read", 64'(ft), 64'd0);
    endtask

    // Serial monitor: samples each bit mid-cell and compares against the scoreboard.
    initial begin : monitor
        exp_t       e;
        logic       have;
        logic       start_b;
        logic [7:0] d;
        logic       p;
        logic       s;
        forever begin
            @(negedge clk);
            if (rst_m === 1'b1 && txd === 1'b0) begin
                have = 1'b0;
                e    = '0;
                p    = 1'b0;
                if (!quiet) begin
                    if (sb_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_frame: got a start bit, required none (t=%0t)", $time);
                    end else begin
                        e    = sb_q.pop_front();
                        have = 1'b1;
                    end
                end
                repeat (CPB / 2) @(negedge clk);
                start_b = txd;
                for (int i = 0; i < 8; i++) begin
                    repeat (CPB) @(negedge clk);
                    d[i] = txd;
                end
                if (have && e.pe) begin
                    repeat (CPB) @(negedge clk);
                    p = txd;
                end
                repeat (CPB) @(negedge clk);
                s = txd;
                if (have) begin
                    check("frame_start_bit", 64'(start_b), 64'd0);
                    check("frame_byte", 64'(d), 64'(e.b));
                    if (e.pe) check("frame_parity", 64'(p), 64'(e.pb));
                    check("frame_stop_bit", 64'(s), 64'd1);
                end
            end
        end
    end

    initial begin : stim
        int fall_c;
        int ft_c;
        rst_m       = 1'b0;
        parity_en   = 1'b0;
        parity_kind = 1'b0;
        read        = 1'b0;
        txd_en      = 1'b0;
        data        = 64'hC16B85393ADB0ECB;

        // 1: reset held 100 ns, then idle with txd_en low
        repeat (5) begin
            @(negedge clk);
            check("reset_txd", 64'(txd), 64'd1);
            check("reset_ft", 64'(ft), 64'd0);
        end
        rst_m = 1'b1;
        repeat (20) begin
            @(negedge clk);
            check("idle_no_enable_txd", 64'(txd), 64'd1);
        end

        // 2: full word without parity, back-to-back frames, 320 clks
        push_word(1'b0, 1'b0);
        txd_en = 1'b1;
        wait_fall(fall_c);
        wait_ft(ft_c);
        check("word_clks_noparity", 64'(ft_c - fall_c), 64'd320);
        check("sb_drained_2", 64'(sb_q.size()), 64'd0);

        // 3: ft blocks resend for 10 us; read clears it and the word repeats
        repeat (500) begin
            @(negedge clk);
            check("hold_txd_high", 64'(txd), 64'd1);
            check("hold_ft_set", 64'(ft), 64'd1);
        end
        ack_ft();
        push_word(1'b0, 1'b0);
        txd_en = 1'b1;
        wait_fall(fall_c);
        wait_ft(ft_c);
        check("word_clks_resend", 64'(ft_c - fall_c), 64'd320);
        check("sb_drained_3", 64'(sb_q.size()), 64'd0);
        ack_ft();

        // 4: even then odd parity, 352 clks per word
        parity_en   = 1'b1;
        parity_kind = 1'b0;
        push_word(1'b1, 1'b0);
        txd_en = 1'b1;
        wait_fall(fall_c);
        wait_ft(ft_c);
        check("word_clks_parity", 64'(ft_c - fall_c), 64'd352);
        check("sb_drained_4e", 64'(sb_q.size()), 64'd0);
        ack_ft();
        parity_kind = 1'b1;
        push_word(1'b1, 1'b1);
        txd_en = 1'b1;
        wait_fall(fall_c);
        wait_ft(ft_c);
        check("word_clks_parity_odd", 64'(ft_c - fall_c), 64'd352);
        check("sb_drained_4o", 64'(sb_q.size()), 64'd0);
        ack_ft();
        parity_en   = 1'b0;
        parity_kind = 1'b0;

        // 5: pause during byte 3, resume with 0x39; data changes after latch are ignored
        push_word(1'b0, 1'b0);
        txd_en = 1'b1;
        wait_fall(fall_c);
        data = '1;
        repeat (90) @(negedge clk);
        txd_en = 1'b0;
        repeat (40) @(negedge clk);
        repeat (60) begin
            @(negedge clk);
            check("gap_txd_high", 64'(txd), 64'd1);
        end
        check("gap_ft_clear", 64'(ft), 64'd0);
        check("gap_remaining_bytes", 64'(sb_q.size()), 64'd5);
        txd_en = 1'b1;
        wait_ft(ft_c);
        check("sb_drained_5", 64'(sb_q.size()), 64'd0);
        ack_ft();
        data = 64'hC16B85393ADB0ECB;

        // 6: reset mid-frame aborts; the next word restarts from 0xC1
        quiet  = 1'b1;
        txd_en = 1'b1;
        wait_fall(fall_c);
        repeat (15) @(negedge clk);
        #5 rst_m = 1'b0;
        #1;
        check("abort_txd", 64'(txd), 64'd1);
        check("abort_ft", 64'(ft), 64'd0);
        txd_en = 1'b0;
        repeat (3) @(negedge clk);
        rst_m = 1'b1;
        repeat (60) @(negedge clk);
        check("post_abort_txd", 64'(txd), 64'd1);
        quiet = 1'b0;
        push_word(1'b0, 1'b0);
        txd_en = 1'b1;
        wait_fall(fall_c);
        wait_ft(ft_c);
        check("word_clks_after_abort", 64'(ft_c - fall_c), 64'd320);
        check("sb_drained_6", 64'(sb_q.size()), 64'd0);
        @(negedge clk);
        #5 rst_m = 1'b0;
        #1;
        check("reset_clears_ft", 64'(ft), 64'd0);
        check("reset_txd_idle", 64'(txd), 64'd1);
        txd_en = 1'b0;
        repeat (3) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
